axi_rd_arbiter: RTL
===================

# axi_rd_arbiter

Two-to-one AXI4 read-channel arbiter that shares the single read port of the on-chip AXI RAM between the instruction-fetch requester (port 0) and the data-load requester (port 1). It accepts AR requests from both masters, grants one whole burst at a time in round-robin order, forwards the single selected AR downstream, and routes the R beats back to the granted master until the `rlast` handshake completes. The write channels bypass this block.

## Interface
Parameters:
- `DATA_WIDTH`, 32, R data width.
- `ADDR_WIDTH`, 16, AR address width.
- `ID_WIDTH`, 8, upstream AXI ID width.

Ports (`sN` is `s0` or `s1`):
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sN_axi_arid`/`araddr`/`arlen`/`arsize`/`arburst`  in  ID_WIDTH/ADDR_WIDTH/8/3/2  upstream request fields.
- `sN_axi_arvalid`  in  1  request valid.
- `sN_axi_arready`  out  1  request accepted.
- `sN_axi_rid`/`rdata`/`rresp`/`rlast`  out  ID_WIDTH/DATA_WIDTH/2/1  returned beat.
- `sN_axi_rvalid`  out  1  beat valid.
- `sN_axi_rready`  in  1  beat accepted.
- `m_axi_arid`  out  MID_WIDTH  downstream ID. MID_WIDTH is ID_WIDTH, or ID_WIDTH+1 with the tag feature.
- `m_axi_araddr`/`arlen`/`arsize`/`arburst`  out  ADDR_WIDTH/8/3/2  registered copy of the granted request.
- `m_axi_arvalid`  out  1.
- `m_axi_arready`  in  1.
- `m_axi_rid`/`rdata`/`rresp`/`rlast`/`rvalid`  in  MID_WIDTH/DATA_WIDTH/2/1/1.
- `m_axi_rready`  out  1.

## Operation
- States: IDLE, ADDR, DATA.
- IDLE:
  - `sN_axi_arready` is asserted combinationally, and only for the master selected by the arbiter.
  - Selection with both `arvalid` high: the master that was not granted last.
  - Selection with one `arvalid` high: that master.
  - On the selected handshake: capture the AR fields into output registers, store `grant`, update `last_grant`, go to ADDR.
- ADDR:
  - `m_axi_arvalid` is 1 and the AR outputs are held stable.
  - On `m_axi_arready`: drop `m_axi_arvalid` and go to DATA.
- DATA:
  - Routing: `s[grant]_axi_r*` = `m_axi_r*`, and `m_axi_rready` = `s[grant]_axi_rready`.
  - The non-granted master sees `rvalid` = 0.
  - On a beat handshake with `rlast`=1, go to IDLE.
- Both `sN_axi_arready` are 0 in ADDR and DATA. Only one burst is outstanding at a time, and there is no reordering.
- A burst is never preempted. The `arlen`+1 beats of one master are never interleaved with the other master's beats.
- R beats arriving outside DATA are not accepted: `m_axi_rready` = 0, and every `sN_axi_rvalid` = 0.

## Timing
- Reset values:
  - state IDLE.
  - `m_axi_arvalid` 0, all `m_axi_ar*` fields 0.
  - `last_grant` = 1, so port 0 wins the first conflict.
  - `m_axi_rready` 0 and all `sN_axi_rvalid` 0 until DATA.
  - `sN_axi_arready` becomes valid from the first cycle after reset.
- AR latency: an upstream handshake in cycle N gives `m_axi_arvalid`=1 in cycle N+1. The earliest downstream acceptance is N+1, and the earliest new upstream acceptance is the cycle after the `rlast` handshake.
- R path is zero-latency combinational pass-through. No R buffering.
- `rst` asserted during ADDR or DATA forces IDLE on the next edge and abandons the burst. The RAM shares the same `rst`, so it abandons its burst too.
- Simultaneous requests in IDLE: exactly one master gets `arready`. The loser holds `arvalid`, per AXI rules, and wins the next arbitration.

## Configuration
- Macro `AXI_RD_ARB_ID_TAG_EN`.
- Defined:
  - MID_WIDTH = ID_WIDTH+1.
  - `m_axi_arid` = {grant, captured `arid`}.
  - R routing uses `m_axi_rid[ID_WIDTH]` instead of the `grant` register.
  - `sN_axi_rid` drops the MSB.
  - A beat whose tag differs from `grant` is forwarded by its tag, and the sticky debug flag `tag_mismatch` is set; it is cleared only by `rst`.
- Undefined: MID_WIDTH = ID_WIDTH, `m_axi_arid` = `arid`, routing by `grant` only, and no `tag_mismatch` flag.

## Structure
- Package `axi_arb_pkg` holds:
  - the state encoding (IDLE=2'd0, ADDR=2'd1, DATA=2'd2);
  - the `AXI_RESP_OKAY`=2'b00 and burst-type constants;
  - the default parameter values.
- Sub-module `rr_arbiter_2`:
  - inputs: `req[1:0]`, `last_grant`;
  - outputs: one-hot `gnt[1:0]` and the `grant` index;
  - purely combinational.
- The `last_grant` register lives in `axi_rd_arbiter`.

## Test plan
- Single master, idle bus: s0 requests `araddr`=0x0040, `arlen`=3, INCR → `m_axi_araddr`=0x0040 one cycle after the handshake, 4 beats to s0 with `rlast` on the 4th, `s1_axi_rvalid` never 1.
- Conflict: s0 and s1 both request in the first cycle after reset → s0 is granted first; s1 is granted the cycle after s0's `rlast` handshake.
- Fairness: both hold `arvalid` continuously for 6 bursts of `arlen`=0 → grants alternate 0,1,0,1,0,1.
- Backpressure: `s1_axi_rready` toggles 1/0 during an 8-beat burst → `m_axi_rready` mirrors it every cycle; data order is preserved, nothing is dropped or duplicated.
- Reset mid-burst: `rst` high for 1 cycle after beat 2 of 4 → IDLE next cycle, all `rvalid`/`arvalid` 0; a new s1 request then completes normally.
- With `AXI_RD_ARB_ID_TAG_EN`: s1 `arid`=0x5A → `m_axi_arid`=0x15A, `s1_axi_rid`=0x5A, `tag_mismatch` stays 0.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared state encoding, AXI constants and default widths
// for the two-to-one AXI4 read-channel arbiter.
package axi_arb_pkg;

  // Arbiter FSM: waiting for a request, presenting AR downstream, streaming R
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  // AXI response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AXI burst types
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  // Default parameter values for axi_rd_arbiter
  localparam int AXI_RD_ARB_DATA_WIDTH = 32;
  localparam int AXI_RD_ARB_ADDR_WIDTH = 16;
  localparam int AXI_RD_ARB_ID_WIDTH   = 8;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: combinational two-requester round-robin picker.
// On a conflict the requester that did not win last time is chosen;
// a lone requester always wins. No request gives gnt = 2'b00.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       grant
);

  // Pick the winner from the current requests and the previous grant
  always_comb begin
    gnt   = 2'b00;
    grant = last_grant;
    case (req)
      2'b01: begin
        gnt   = 2'b01;
        grant = 1'b0;
      end
      2'b10: begin
        gnt   = 2'b10;
        grant = 1'b1;
      end
      2'b11: begin
        if (last_grant) begin
          gnt   = 2'b01;
          grant = 1'b0;
        end else begin
          gnt   = 2'b10;
          grant = 1'b1;
        end
      end
      default: begin
        gnt   = 2'b00;
        grant = last_grant;
      end
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 read port between the instruction-fetch
// master (s0) and the data-load master (s1). One whole burst is granted at a
// time in round-robin order; the R channel is a combinational pass-through to
// the granted master until the rlast handshake.
// Optional feature macro: AXI_RD_ARB_ID_TAG_EN -- widens the downstream ID by
// one bit carrying the grant, routes R beats by that tag and adds the sticky
// tag_mismatch debug flag.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int DATA_WIDTH = AXI_RD_ARB_DATA_WIDTH,
  parameter int ADDR_WIDTH = AXI_RD_ARB_ADDR_WIDTH,
  parameter int ID_WIDTH   = AXI_RD_ARB_ID_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef AXI_RD_ARB_ID_TAG_EN
  output logic                  tag_mismatch,
`endif

  // upstream port 0 (instruction fetch)
  input  logic [ID_WIDTH-1:0]   s0_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic [7:0]            s0_axi_arlen,
  input  logic [2:0]            s0_axi_arsize,
  input  logic [1:0]            s0_axi_arburst,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  output logic [ID_WIDTH-1:0]   s0_axi_rid,
  output logic [DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [1:0]            s0_axi_rresp,
  output logic                  s0_axi_rlast,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,

  // upstream port 1 (data load)
  input  logic [ID_WIDTH-1:0]   s1_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic [7:0]            s1_axi_arlen,
  input  logic [2:0]            s1_axi_arsize,
  input  logic [1:0]            s1_axi_arburst,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  output logic [ID_WIDTH-1:0]   s1_axi_rid,
  output logic [DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [1:0]            s1_axi_rresp,
  output logic                  s1_axi_rlast,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,

  // downstream port to the AXI RAM
`ifdef AXI_RD_ARB_ID_TAG_EN
  output logic [ID_WIDTH:0]     m_axi_arid,
`else
  output logic [ID_WIDTH-1:0]   m_axi_arid,
`endif
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
`ifdef AXI_RD_ARB_ID_TAG_EN
  input  logic [ID_WIDTH:0]     m_axi_rid,
`else
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
`endif
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  arb_state_t state;
  arb_state_t state_next;

  // grant owns the current burst; last_grant steers the next conflict
  logic grant;
  logic last_grant;

  // captured copy of the granted AR request
  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;

  logic [1:0] arb_gnt;
  logic       arb_idx;
  logic       ar_take;
  logic       in_data;
  logic       route;
  logic       r_done;

  rr_arbiter_2 u_rr_arbiter_2 (
    .req        ({s1_axi_arvalid, s0_axi_arvalid}),
    .last_grant (last_grant),
    .gnt        (arb_gnt),
    .grant      (arb_idx)
  );

  assign in_data = (state == DATA);
  assign r_done  = in_data && m_axi_rvalid && m_axi_rready && m_axi_rlast;

`ifdef AXI_RD_ARB_ID_TAG_EN
  assign route      = m_axi_rid[ID_WIDTH];
  assign m_axi_arid = {grant, ar_id};
`else
  assign route      = grant;
  assign m_axi_arid = ar_id;
`endif

  assign m_axi_araddr  = ar_addr;
  assign m_axi_arlen   = ar_len;
  assign m_axi_arsize  = ar_size;
  assign m_axi_arburst = ar_burst;

  // R payload fans out to both masters; only rvalid qualifies it
  assign s0_axi_rid   = m_axi_rid[ID_WIDTH-1:0];
  assign s0_axi_rdata = m_axi_rdata;
  assign s0_axi_rresp = m_axi_rresp;
  assign s0_axi_rlast = m_axi_rlast;
  assign s1_axi_rid   = m_axi_rid[ID_WIDTH-1:0];
  assign s1_axi_rdata = m_axi_rdata;
  assign s1_axi_rresp = m_axi_rresp;
  assign s1_axi_rlast = m_axi_rlast;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, upstream arready and downstream arvalid
  always_comb begin
    state_next     = state;
    s0_axi_arready = 1'b0;
    s1_axi_arready = 1'b0;
    m_axi_arvalid  = 1'b0;
    ar_take        = 1'b0;
    case (state)
      IDLE: begin
        s0_axi_arready = arb_gnt[0];
        s1_axi_arready = arb_gnt[1];
        ar_take        = |arb_gnt;
        if (ar_take) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (r_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the granted request and remember who won it
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      ar_id      <= '0;
      ar_addr    <= '0;
      ar_len     <= '0;
      ar_size    <= '0;
      ar_burst   <= '0;
    end else if (ar_take) begin
      grant      <= arb_idx;
      last_grant <= arb_idx;
      if (arb_idx) begin
        ar_id    <= s1_axi_arid;
        ar_addr  <= s1_axi_araddr;
        ar_len   <= s1_axi_arlen;
        ar_size  <= s1_axi_arsize;
        ar_burst <= s1_axi_arburst;
      end else begin
        ar_id    <= s0_axi_arid;
        ar_addr  <= s0_axi_araddr;
        ar_len   <= s0_axi_arlen;
        ar_size  <= s0_axi_arsize;
        ar_burst <= s0_axi_arburst;
      end
    end
  end

  // Steer R handshakes to the burst owner; nothing is accepted outside DATA
  always_comb begin
    s0_axi_rvalid = in_data && m_axi_rvalid && !route;
    s1_axi_rvalid = in_data && m_axi_rvalid && route;
    m_axi_rready  = in_data && (route ? s1_axi_rready : s0_axi_rready);
  end

`ifdef AXI_RD_ARB_ID_TAG_EN
  // Sticky flag: a beat came back tagged for the master not holding the grant
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_mismatch <= 1'b0;
    end else if (in_data && m_axi_rvalid && (m_axi_rid[ID_WIDTH] != grant)) begin
      tag_mismatch <= 1'b1;
    end
  end
`endif

endmodule
